// File: rtl/cpu_pkg.sv
// Register-file shared definitions: bank geometry and the write-request record.
package cpu_pkg;

  localparam int REG_AW = 3;
  localparam int REG_DW = 16;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] win,
  output logic                 any
);

  localparam int SW = $clog2(N);

  int idx;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        win        = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with one registered output slot.
module regfile_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = REG_DW,
  parameter int AW   = REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic [$clog2(NREQ)-1:0]  wr_src
);

  localparam int SW = $clog2(NREQ);

  logic [SW-1:0]   ptr_q, ptr_d;
  logic            slot_valid_q, slot_valid_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [SW-1:0]   wr_src_q, wr_src_d;

  logic [NREQ-1:0] grant;
  logic [SW-1:0]   win;
  logic            any;
  logic            slot_free;
  logic            accept;

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  // Handshake: a write transfers in the cycle req_valid[i] & req_ready[i]; the requester
  // holds addr/data/valid stable until then. Grants only happen when the slot is free
  // (empty, or draining this cycle), and never while reset is asserted.
  assign slot_free = !slot_valid_q || !wr_stall;
  assign accept    = slot_free && any && rst_n;
  assign req_ready = accept ? grant : '0;

  assign wr_en   = slot_valid_q && !wr_stall;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

  always_comb begin
    ptr_d        = ptr_q;
    slot_valid_d = slot_valid_q && wr_stall;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_src_d     = wr_src_q;
    if (accept) begin
      slot_valid_d = 1'b1;
      wr_addr_d    = req_addr[int'(win)*AW +: AW];
      wr_data_d    = req_data[int'(win)*DW +: DW];
      wr_src_d     = win;
      ptr_d        = (win == SW'(NREQ-1)) ? '0 : win + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      slot_valid_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_src_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      slot_valid_q <= slot_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: spec-level round-robin model, expected-write queue, bank model.
module tb_regfile_wr_arbiter;
  import cpu_pkg::*;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int W  = 2 + AW + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wr_stall = 1'b0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_src;

  regfile_wr_arbiter #(.NREQ(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  // scoreboard and model state
  logic [W-1:0]  exp_q[$];
  int            glog[$];
  logic [DW-1:0] wlog[$];
  logic [DW-1:0] bank[8];
  logic [N-1:0]  pend_v = '0;
  wr_req_t       pend_r[N];
  int            m_ptr = 0;
  logic          m_slot = 1'b0;
  logic          refill = 1'b0;
  int            wr_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_search(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    pend_v[i]      = 1'b1;
    pend_r[i].addr = 3'($urandom_range(0, 7));
    pend_r[i].data = 16'($urandom_range(0, 65535));
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[i]      = 1'b1;
    pend_r[i].addr = a;
    pend_r[i].data = d;
  endtask

  task automatic drive_inputs();
    req_valid = pend_v;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = pend_v[i] ? pend_r[i].addr : '0;
      req_data[i*DW +: DW] = pend_v[i] ? pend_r[i].data : '0;
    end
  endtask

  // One clock: drive at negedge, check #1 later, advance model, end at next negedge.
  task automatic step(input logic stall);
    int         win;
    logic       slot_free;
    logic [N-1:0] exp_ready;
    wr_stall = stall;
    drive_inputs();
    #1;
    slot_free = !m_slot || !stall;
    win       = slot_free ? rr_search(pend_v, m_ptr) : -1;
    exp_ready = (win >= 0) ? N'(1 << win) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("wr_en", 32'(wr_en), 32'(m_slot && !stall));
    if (m_slot && exp_q.size() > 0) begin
      check("held_write", 32'({wr_src, wr_addr, wr_data}), 32'(exp_q[0]));
      if (!stall) void'(exp_q.pop_front());
    end
    if (wr_en) begin
      wr_cnt++;
      bank[wr_addr] = wr_data;
      wlog.push_back(wr_data);
    end
    if (win >= 0) begin
      exp_q.push_back({2'(win), pend_r[win].addr, pend_r[win].data});
      glog.push_back(win);
      pend_v[win] = 1'b0;
      m_ptr       = (win + 1) % N;
      m_slot      = 1'b1;
      if (refill) new_req(win);
    end else if (slot_free) begin
      m_slot = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) pend_r[i] = '0;
    for (int i = 0; i < 8; i++) bank[i] = '0;

    // reset state
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_wr_src", 32'(wr_src), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single write from requester 2
    set_req(2, 3'd5, 16'hBEEF);
    step(1'b0);
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_addr", 32'(wr_addr), 32'd5);
    check("single_data", 32'(wr_data), 32'hBEEF);
    check("single_src", 32'(wr_src), 32'd2);
    step(1'b0);
    check("single_done", 32'(wr_en), 32'd0);

    // wrap from ptr=3
    glog.delete();
    set_req(0, 3'd1, 16'h0A0A);
    set_req(1, 3'd2, 16'h0B0B);
    step(1'b0);
    step(1'b0);
    check("wrap1_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("wrap1_first", 32'(glog[0]), 32'd0);
      check("wrap1_second", 32'(glog[1]), 32'd1);
    end
    set_req(2, 3'd3, 16'h0C0C);
    step(1'b0);
    glog.delete();
    set_req(0, 3'd4, 16'h0D0D);
    set_req(3, 3'd6, 16'h0E0E);
    step(1'b0);
    step(1'b0);
    check("wrap2_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("wrap2_first", 32'(glog[0]), 32'd3);
      check("wrap2_second", 32'(glog[1]), 32'd0);
    end
    step(1'b0);

    // reset mid-stream with the slot full
    set_req(1, 3'd7, 16'h7777);
    step(1'b0);
    new_req(2);
    drive_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_slot = 1'b0;
    exp_q.delete();
    pend_v = '0;
    glog.delete();
    new_req(3);
    step(1'b0);
    check("rst_grant3", 32'(glog.size() == 1 && glog[0] == 3), 32'd1);

    // fairness: all valid continuously, ptr starts at 0
    glog.delete();
    wr_cnt = 0;
    refill = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    repeat (8) step(1'b0);
    refill = 1'b0;
    check("fair_n", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < glog.size()) check($sformatf("fair_grant%0d", k), 32'(glog[k]), 32'(k % N));
    end
    check("fair_wr_cnt", 32'(wr_cnt), 32'd8);
    repeat (5) step(1'b0);

    // stall holds the slot and blocks grants
    set_req(1, 3'd1, 16'h0042);
    step(1'b0);
    new_req(3);
    glog.delete();
    repeat (3) begin
      step(1'b1);
      check("stall_wr_en", 32'(wr_en), 32'd0);
      check("stall_addr", 32'(wr_addr), 32'd1);
      check("stall_data", 32'(wr_data), 32'h0042);
      check("stall_src", 32'(wr_src), 32'd1);
    end
    step(1'b0);
    check("stall_release_grant", 32'(glog.size() == 1 && glog[0] == 3), 32'd1);
    step(1'b0);

    // same destination from two requesters
    wlog.delete();
    set_req(0, 3'd4, 16'h1111);
    set_req(1, 3'd4, 16'h2222);
    repeat (3) step(1'b0);
    check("coll_n", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("coll_first", 32'(wlog[0]), 32'h1111);
      check("coll_second", 32'(wlog[1]), 32'h2222);
    end
    check("coll_bank", 32'(bank[4]), 32'h2222);

    // random traffic with random stalls
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) new_req(i);
      end
      step($urandom_range(0, 3) == 0);
    end
    repeat (8) step(1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_pending", 32'(pend_v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
